// File: rtl/reverse_dabble_pkg.sv
// Shared definitions for the reverse double-dabble BCD-to-binary converter.
// State encoding, digit width and the shift-right/subtract-3 correction constants.
package reverse_dabble_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int          DIGIT_BITS  = 4;
    localparam logic [3:0]  CORR_THRESH = 4'd8;
    localparam logic [3:0]  CORR_SUB    = 4'd3;

    function automatic logic digit_invalid(input logic [DIGIT_BITS-1:0] digit);
        return digit > 4'd9;
    endfunction

endpackage

// File: rtl/dabble_digit_correct.sv
// Single BCD nibble correction for reverse double-dabble: digits >= 8 lose 3.
// Purely combinational; one instance per BCD digit.
module dabble_digit_correct
    import reverse_dabble_pkg::*;
(
    input  logic [DIGIT_BITS-1:0] digit_i,
    output logic [DIGIT_BITS-1:0] digit_o
);

    assign digit_o = (digit_i >= CORR_THRESH) ? (digit_i - CORR_SUB) : digit_i;

endmodule

// File: rtl/reverse_dabble.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result per OUTPUT_BITS cycles.
// Optional macro REVERSE_DABBLE_DIGIT_CHECK_EN adds Error_o and forces the result to 0 on non-decimal digits.
//
// state    | meaning
// ST_IDLE  | waiting for Start_i, results held
// ST_SHIFT | shifting right and correcting digits, one iteration per cycle
module reverse_dabble
    import reverse_dabble_pkg::*;
#(
    parameter int INPUT_DIGITS = 3,
    parameter int OUTPUT_BITS  = 10
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [INPUT_DIGITS*4-1:0]      BCD_i,
    input  logic                           Start_i,
    output logic                           Busy_o,
    output logic                           Done_o,
    output logic [OUTPUT_BITS-1:0]         Binary_o,
`ifdef REVERSE_DABBLE_DIGIT_CHECK_EN
    output logic                           Error_o,
`endif
    output logic                           Overflow_o
);

    localparam int BCD_W = INPUT_DIGITS * DIGIT_BITS;
    localparam int CNT_W = $clog2(OUTPUT_BITS + 1);
    localparam int REG_W = BCD_W + OUTPUT_BITS;

    state_t                 state_q, state_d;
    logic [REG_W-1:0]       work_q, work_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [OUTPUT_BITS-1:0] bin_q, bin_d;
    logic                   ovf_q, ovf_d;

    logic [BCD_W-1:0]       bcd_shift, bcd_corr;
    logic [OUTPUT_BITS-1:0] bin_shift;
    logic                   last_iter;

    assign {bcd_shift, bin_shift} = work_q >> 1;
    assign last_iter = (cnt_q == CNT_W'(OUTPUT_BITS - 1));

    for (genvar g = 0; g < INPUT_DIGITS; g++) begin : g_corr
        dabble_digit_correct u_corr (
            .digit_i (bcd_shift[g*DIGIT_BITS +: DIGIT_BITS]),
            .digit_o (bcd_corr[g*DIGIT_BITS +: DIGIT_BITS])
        );
    end

`ifdef REVERSE_DABBLE_DIGIT_CHECK_EN
    // Bad-digit flag is captured at start and only published alongside Done_o.
    logic chk_q, chk_d;
    logic err_q, err_d;
    logic start_bad;

    always_comb begin
        start_bad = 1'b0;
        for (int i = 0; i < INPUT_DIGITS; i++) begin
            start_bad = start_bad | digit_invalid(BCD_i[i*DIGIT_BITS +: DIGIT_BITS]);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            chk_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            chk_q <= chk_d;
            err_q <= err_d;
        end
    end

    assign Error_o = err_q;
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
`ifdef REVERSE_DABBLE_DIGIT_CHECK_EN
        chk_d   = chk_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start_i) begin
                    work_d  = {BCD_i, {OUTPUT_BITS{1'b0}}};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
`ifdef REVERSE_DABBLE_DIGIT_CHECK_EN
                    chk_d   = start_bad;
`endif
                end
            end
            ST_SHIFT: begin
                work_d = {bcd_corr, bin_shift};
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    bin_d   = bin_shift;
                    ovf_d   = |bcd_corr;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
`ifdef REVERSE_DABBLE_DIGIT_CHECK_EN
                    err_d   = chk_q;
                    if (chk_q) begin
                        bin_d = '0;
                        ovf_d = 1'b0;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Busy_o     = busy_q;
    assign Done_o     = done_q;
    assign Binary_o   = bin_q;
    assign Overflow_o = ovf_q;

endmodule
